// File: rtl/cpu_mux_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mux_pkg
// Shared definitions for the operand-select pipeline blocks:
//   - DATA_W   : default datapath word width
//   - ST_*     : skid-buffer state encoding (2'd3 is illegal, recovers to EMPTY)
//   - clog2()  : constant-evaluable ceiling log2 used to size select ports
// -----------------------------------------------------------------------------
package cpu_mux_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // Smallest r with 2**r >= n; callers guarantee n >= 2.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_skid_buffer.sv
// -----------------------------------------------------------------------------
// mux_skid_buffer
// Generic 2-entry valid/ready skid buffer. in_ready and out_valid are decoded
// only from the registered state, so there is no combinational path from
// out_ready to in_ready. Entries leave in strict FIFO order; the output
// register (main) is always the head.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (drops all entries)
//   in_data    entry offered by upstream
//   in_valid   upstream offers in_data
//   in_ready   buffer can take an entry this cycle (registered decode)
//   out_data   head entry (main register)
//   out_valid  out_data holds a live entry
//   out_ready  downstream takes the head entry
// -----------------------------------------------------------------------------
module mux_skid_buffer
    import cpu_mux_pkg::*;
#(
    parameter int DW = DATA_W + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] main_q,  main_d;
    logic [DW-1:0] skid_q,  skid_d;
    logic          accept;
    logic          pop;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_d = in_data;
                end else if (accept) begin
                    // Head is stalled: park the newcomer behind it.
                    skid_d  = in_data;
                    state_d = ST_TWO;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/pipe_mux.sv
// -----------------------------------------------------------------------------
// pipe_mux
// NUM_IN-to-1, WIDTH-bit operand selector with a registered, back-pressured
// output. A combinational front end picks the word and flags out-of-range
// selects; {err, word} then travels through a 2-entry skid buffer as a single
// entry. Out-of-range accepts are counted in a saturating counter.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    flattened inputs, word i at in_data[i*WIDTH +: WIDTH]
//   sel        input index, sampled with in_data on accept
//   in_valid   upstream offers {in_data, sel}
//   in_ready   block can accept this cycle (registered)
//   out_data   selected word (0 for an out-of-range select)
//   out_err    out_data came from an out-of-range select
//   out_valid  out_data / out_err are valid
//   out_ready  downstream takes the output
//   err_count  saturating count of accepted out-of-range selects
// -----------------------------------------------------------------------------
module pipe_mux
    import cpu_mux_pkg::*;
#(
    parameter  int WIDTH  = DATA_W,
    parameter  int NUM_IN = 32,
    parameter  int CNT_W  = 8,
    localparam int SEL_W  = clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNT_W-1:0]        err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0]      sel_ext;
    logic             in_range;
    logic [WIDTH-1:0] word;
    logic [WIDTH:0]   buf_in;
    logic [WIDTH:0]   buf_out;
    logic             accept;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign sel_ext  = 32'(sel);
    // Always true when NUM_IN is a power of two; the error path then folds away.
    assign in_range = (sel_ext < 32'(NUM_IN));

    // One-hot style compare keeps every index in bounds; no match leaves word at 0.
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel_ext == 32'(i)) word = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign buf_in = {~in_range, word};

    mux_skid_buffer #(
        .DW (WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (buf_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (buf_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_err  = buf_out[WIDTH];
    assign out_data = buf_out[WIDTH-1:0];

    assign accept = in_valid & in_ready;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && !in_range && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_pipe_mux.sv
module tb_pipe_mux;

    // dut_a: NUM_IN=32 (power of two), CNT_W=8
    // dut_b: NUM_IN=20 (has out-of-range selects), CNT_W=2
    logic clk;
    logic rst;

    logic [32*32-1:0] a_in_data;
    logic [4:0]       a_sel;
    logic             a_in_valid, a_in_ready;
    logic [31:0]      a_out_data;
    logic             a_out_err, a_out_valid, a_out_ready;
    logic [7:0]       a_err_count;

    logic [20*32-1:0] b_in_data;
    logic [4:0]       b_sel;
    logic             b_in_valid, b_in_ready;
    logic [31:0]      b_out_data;
    logic             b_out_err, b_out_valid, b_out_ready;
    logic [1:0]       b_err_count;

    logic [31:0] bw [20];

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] data;
        logic        err;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl [7];

    logic [32:0] q [$];
    int          mcnt;

    pipe_mux #(.WIDTH(32), .NUM_IN(32), .CNT_W(8)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_data   (a_in_data),
        .sel       (a_sel),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_data  (a_out_data),
        .out_err   (a_out_err),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .err_count (a_err_count)
    );

    pipe_mux #(.WIDTH(32), .NUM_IN(20), .CNT_W(2)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_data   (b_in_data),
        .sel       (b_sel),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_data  (b_out_data),
        .out_err   (b_out_err),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .err_count (b_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 20; i++) b_in_data[i*32 +: 32] = bw[i];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [32:0] e;
        logic        stall, acc, pop;
        logic [32:0] hold_e;

        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) a_in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 20; i++) bw[i] = 32'hB000_0000 + 32'(i);

        // ---- 1: reset held 3 cycles with traffic offered ----
        rst = 1'b1;
        a_sel = 5'd4;  a_in_valid = 1'b1; a_out_ready = 1'b0;
        b_sel = 5'd25; b_in_valid = 1'b1; b_out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rst_a_valid", 64'(a_out_valid), 64'd0);
            chk("rst_a_ready", 64'(a_in_ready), 64'd1);
            chk("rst_a_data",  64'(a_out_data), 64'd0);
            chk("rst_a_err",   64'(a_out_err), 64'd0);
            chk("rst_a_cnt",   64'(a_err_count), 64'd0);
            chk("rst_b_valid", 64'(b_out_valid), 64'd0);
            chk("rst_b_ready", 64'(b_in_ready), 64'd1);
            chk("rst_b_cnt",   64'(b_err_count), 64'd0);
        end
        rst = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;

        // ---- 2: back-to-back throughput on dut_a ----
        a_out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            a_sel = 5'(i);
            a_in_valid = 1'b1;
            tick();
            chk("thr_valid", 64'(a_out_valid), 64'd1);
            chk("thr_data",  64'(a_out_data), 64'(32'hA000_0000 + 32'(i)));
            chk("thr_ready", 64'(a_in_ready), 64'd1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("thr_drain", 64'(a_out_valid), 64'd0);

        // ---- 3: backpressure, two entries then release ----
        a_out_ready = 1'b0;
        a_sel = 5'd3; a_in_valid = 1'b1;
        tick();
        chk("bp_first_data",  64'(a_out_data), 64'h0000_0000_A000_0003);
        chk("bp_first_ready", 64'(a_in_ready), 64'd1);
        a_sel = 5'd7;
        tick();
        chk("bp_full_ready", 64'(a_in_ready), 64'd0);
        chk("bp_full_data",  64'(a_out_data), 64'h0000_0000_A000_0003);
        a_in_valid = 1'b0;
        tick();
        chk("bp_hold_data",  64'(a_out_data), 64'h0000_0000_A000_0003);
        chk("bp_hold_ready", 64'(a_in_ready), 64'd0);
        a_out_ready = 1'b1;
        tick();
        chk("bp_second_valid", 64'(a_out_valid), 64'd1);
        chk("bp_second_data",  64'(a_out_data), 64'h0000_0000_A000_0007);
        chk("bp_second_ready", 64'(a_in_ready), 64'd1);
        tick();
        chk("bp_empty", 64'(a_out_valid), 64'd0);

        // ---- 4: table of selects on dut_b (NUM_IN=20, CNT_W=2) ----
        tbl[0] = '{sel: 5'd25, data: 32'h0,          err: 1'b1, cnt: 2'd1};
        tbl[1] = '{sel: 5'd5,  data: 32'hB000_0005, err: 1'b0, cnt: 2'd1};
        tbl[2] = '{sel: 5'd19, data: 32'hB000_0013, err: 1'b0, cnt: 2'd1};
        tbl[3] = '{sel: 5'd20, data: 32'h0,          err: 1'b1, cnt: 2'd2};
        tbl[4] = '{sel: 5'd0,  data: 32'hB000_0000, err: 1'b0, cnt: 2'd2};
        tbl[5] = '{sel: 5'd31, data: 32'h0,          err: 1'b1, cnt: 2'd3};
        tbl[6] = '{sel: 5'd21, data: 32'h0,          err: 1'b1, cnt: 2'd3};
        b_out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            b_sel = tbl[k].sel;
            b_in_valid = 1'b1;
            tick();
            chk($sformatf("tbl%0d_valid", k), 64'(b_out_valid), 64'd1);
            chk($sformatf("tbl%0d_data", k),  64'(b_out_data), 64'(tbl[k].data));
            chk($sformatf("tbl%0d_err", k),   64'(b_out_err), 64'(tbl[k].err));
            chk($sformatf("tbl%0d_cnt", k),   64'(b_err_count), 64'(tbl[k].cnt));
        end
        b_in_valid = 1'b0;
        tick();

        // ---- 5: saturation from a fresh reset ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("sat_cleared", 64'(b_err_count), 64'd0);
        begin
            logic [4:0] bad_sel [5];
            logic [1:0] exp_cnt [5];
            bad_sel = '{5'd20, 5'd25, 5'd31, 5'd22, 5'd23};
            exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
            for (int k = 0; k < 5; k++) begin
                b_sel = bad_sel[k];
                b_in_valid = 1'b1;
                tick();
                chk($sformatf("sat%0d_cnt", k), 64'(b_err_count), 64'(exp_cnt[k]));
                chk($sformatf("sat%0d_err", k), 64'(b_out_err), 64'd1);
            end
        end
        b_in_valid = 1'b0;
        tick();

        // ---- 6: reset while dut_a holds two entries ----
        a_out_ready = 1'b0;
        a_sel = 5'd1; a_in_valid = 1'b1;
        tick();
        a_sel = 5'd2;
        tick();
        chk("mid_full", 64'(a_in_ready), 64'd0);
        a_in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_valid", 64'(a_out_valid), 64'd0);
        chk("mid_ready", 64'(a_in_ready), 64'd1);
        chk("mid_data",  64'(a_out_data), 64'd0);
        a_out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mid_dropped", 64'(a_out_valid), 64'd0);
        end

        // ---- random traffic on dut_b against a FIFO model ----
        q.delete();
        mcnt = 0;
        b_in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            // upstream must hold its offer while the model says the block is full
            if (!(b_in_valid && q.size() == 2)) begin
                b_in_valid = ($urandom_range(0, 99) < 65);
                b_sel = 5'($urandom_range(0, 31));
                for (int i = 0; i < 20; i++) bw[i] = $urandom();
            end
            b_out_ready = ($urandom_range(0, 99) < 55);
            #1;

            stall  = (q.size() > 0) && !b_out_ready;
            hold_e = (q.size() > 0) ? q[0] : 33'd0;
            acc    = b_in_valid && (q.size() < 2);
            pop    = (q.size() > 0) && b_out_ready;
            if (b_sel < 5'd20) e = {1'b0, bw[b_sel]};
            else               e = {1'b1, 32'h0};
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (acc && e[32] && mcnt < 3) mcnt++;

            tick();
            chk("rnd_valid", 64'(b_out_valid), 64'(q.size() > 0));
            chk("rnd_ready", 64'(b_in_ready), 64'(q.size() < 2));
            chk("rnd_cnt",   64'(b_err_count), 64'(mcnt));
            if (q.size() > 0) begin
                chk("rnd_head", 64'({b_out_err, b_out_data}), 64'(q[0]));
            end
            if (stall) begin
                chk("rnd_stable", 64'({b_out_err, b_out_data}), 64'(hold_e));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
